fmul_iter: RTL and testbench

//   Multi-cycle IEEE-754 single-precision multiplier. Shift-add mantissa datapath with a start/valid handshake.

---
 rtl/fmul_iter.sv | 215 +++++++++++++++++++++
 tb/tb_fmul_iter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_iter.sv
// fmul_iter: multi-cycle IEEE-754 single-precision multiplier.
// The mantissa product is built by a shift-add datapath that retires
// BITS_PER_CYCLE multiplier bits per cycle. Operands are captured on an
// accepted start; y/ovf are updated together with a one-cycle valid pulse.
// Optional feature macro: FMUL_ITER_ROUND_EN selects round-to-nearest-even;
// without it the fraction is truncated and no rounding logic is built.
// Denormal inputs are flushed to zero; exponent 255 inputs are treated as
// ordinary finite encodings.
module fmul_iter #(
    parameter int BITS_PER_CYCLE = 1   // must divide 24: 1,2,3,4,6,8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        start,
    output logic        busy,
    output logic [31:0] y,
    output logic        ovf,
    output logic        valid
);

    localparam int STEPS = 24 / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] STEPS_INIT = CW'(STEPS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_NORM,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic               zero_q, zero_d;
    logic signed [9:0]  esum_q, esum_d;
    logic [47:0]        mcand_q, mcand_d;
    logic [23:0]        mplier_q, mplier_d;
    logic [47:0]        acc_q, acc_d;
    logic [CW-1:0]      count_q, count_d;
    logic [31:0]        res_q, res_d;
    logic               res_ovf_q, res_ovf_d;
    logic [31:0]        y_q, y_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;

    // One partial product per multiplier bit retired this cycle.
    logic [47:0] pp_terms [BITS_PER_CYCLE];
    logic [47:0] pp_sum;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
            assign pp_terms[gi] = mplier_q[gi] ? (mcand_q << gi) : 48'd0;
        end
    endgenerate

    // Sum the partial products for this step.
    always_comb begin
        pp_sum = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            pp_sum = pp_sum + pp_terms[k];
        end
    end

    // Normalise the 48-bit product: the leading one sits in bit 47 or 46.
    logic signed [9:0] e_norm;
    logic [22:0]       frac_norm;
    logic signed [9:0] e_fin;
    logic [22:0]       frac_fin;

    // Pick the fraction window and biased exponent from the leading bit.
    always_comb begin
        if (acc_q[47]) begin
            e_norm    = esum_q - 10'sd126;
            frac_norm = acc_q[46:24];
        end else begin
            e_norm    = esum_q - 10'sd127;
            frac_norm = acc_q[45:23];
        end
    end

`ifdef FMUL_ITER_ROUND_EN
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] frac_inc;

    // Round to nearest, ties to even; a fraction carry bumps the exponent
    // and leaves the fraction at zero.
    always_comb begin
        guard    = acc_q[47] ? acc_q[23] : acc_q[22];
        sticky   = acc_q[47] ? (|acc_q[22:0]) : (|acc_q[21:0]);
        round_up = guard & (sticky | frac_norm[0]);
        frac_inc = {1'b0, frac_norm} + {23'd0, round_up};
        e_fin    = frac_inc[23] ? (e_norm + 10'sd1) : e_norm;
        frac_fin = frac_inc[22:0];
    end
`else
    // Truncation: guard and sticky bits are simply dropped.
    assign e_fin    = e_norm;
    assign frac_fin = frac_norm;
`endif

    logic [31:0] norm_y;
    logic        norm_ovf;

    // Final packing; zero operands win over overflow and underflow.
    always_comb begin
        norm_ovf = 1'b0;
        if (zero_q) begin
            norm_y = {sign_q, 31'd0};
        end else if (e_fin >= 10'sd255) begin
            norm_y   = {sign_q, 8'hFF, 23'd0};
            norm_ovf = 1'b1;
        end else if (e_fin <= 10'sd0) begin
            norm_y = {sign_q, 31'd0};
        end else begin
            norm_y = {sign_q, e_fin[7:0], frac_fin};
        end
    end

    // Next-state and datapath updates for IDLE -> MUL -> NORM -> DONE.
    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        zero_d    = zero_q;
        esum_d    = esum_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        res_d     = res_q;
        res_ovf_d = res_ovf_q;
        y_d       = y_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_d   = x1[31] ^ x2[31];
                    zero_d   = (x1[30:23] == 8'd0) | (x2[30:23] == 8'd0);
                    esum_d   = $signed({2'b00, x1[30:23]} + {2'b00, x2[30:23]});
                    mcand_d  = {24'd0, 1'b1, x1[22:0]};
                    mplier_d = {1'b1, x2[22:0]};
                    acc_d    = '0;
                    count_d  = STEPS_INIT;
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                acc_d    = acc_q + pp_sum;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                count_d  = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                res_d     = norm_y;
                res_ovf_d = norm_ovf;
                state_d   = S_DONE;
            end
            S_DONE: begin
                y_d     = res_q;
                ovf_d   = res_ovf_q;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sign_q    <= 1'b0;
            zero_q    <= 1'b0;
            esum_q    <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
            y_q       <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            zero_q    <= zero_d;
            esum_q    <= esum_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
            y_q       <= y_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign y     = y_q;
    assign ovf   = ovf_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_fmul_iter.sv
// Self-checking bench for fmul_iter: directed cases, randomized operands
// against an arithmetic reference model, start-held and mid-op reset cases.
module tb_fmul_iter;

    localparam int BPC = 1;
    localparam int LAT = 24 / BPC + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x1, x2;
    logic        start;
    logic        busy;
    logic [31:0] y;
    logic        ovf;
    logic        valid;

    int total = 0;
    int bad   = 0;

    fmul_iter #(.BITS_PER_CYCLE(BPC)) dut (
        .clk   (clk),
        .rst   (rst),
        .x1    (x1),
        .x2    (x2),
        .start (start),
        .busy  (busy),
        .y     (y),
        .ovf   (ovf),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: exact 48-bit product, then normalise, round, classify.
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] ma, mb, p;
        logic [22:0] frac;
        logic        g, st;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {1'b0, s, 31'd0};
        ma = {24'd0, 1'b1, a[22:0]};
        mb = {24'd0, 1'b1, b[22:0]};
        p  = ma * mb;
        if (p[47]) begin
            e = int'(a[30:23]) + int'(b[30:23]) - 126;
            frac = p[46:24]; g = p[23]; st = |p[22:0];
        end else begin
            e = int'(a[30:23]) + int'(b[30:23]) - 127;
            frac = p[45:23]; g = p[22]; st = |p[21:0];
        end
`ifdef FMUL_ITER_ROUND_EN
        if (g && (st || frac[0])) begin
            if (frac == 23'h7FFFFF) begin
                frac = 23'd0;
                e = e + 1;
            end else begin
                frac = frac + 23'd1;
            end
        end
`else
        g = g & st;
`endif
        if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
        if (e <= 0)   return {1'b0, s, 31'd0};
        return {1'b0, s, e[7:0], frac};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [7:0] e;
        if ($urandom_range(0, 7) == 0) e = 8'd0;
        else if ($urandom_range(0, 1) == 0) e = 8'($urandom_range(100, 154));
        else e = 8'($urandom_range(1, 254));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // Issue one operation and wait (bounded) for its valid pulse.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] yo, output logic ovo, output int lat);
        @(negedge clk);
        x1 = a; x2 = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val("busy_after_accept", {31'd0, busy}, 32'd1);
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                lat = n;
                break;
            end
        end
        yo = y;
        ovo = ovf;
    endtask

    task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ey, input logic eovf);
        logic [31:0] yo;
        logic        ovo;
        int          lat;
        run_op(a, b, yo, ovo, lat);
        check_val({tag, "_lat"}, lat, LAT);
        check_val({tag, "_y"}, yo, ey);
        check_val({tag, "_ovf"}, {31'd0, ovo}, {31'd0, eovf});
        @(posedge clk);
        #1;
        check_val({tag, "_pulse"}, {31'd0, valid}, 32'd0);
        check_val({tag, "_hold"}, y, ey);
        $display("op %s: %08h * %08h -> y=%08h ovf=%0d lat=%0d", tag, a, b, yo, ovo, lat);
    endtask

    logic [31:0] ta [40];
    logic [31:0] tb2 [40];
    int          vcyc [$];
    logic [31:0] vy [$];
    logic [32:0] r;
    int          stray;

    initial begin
        rst = 1'b1; start = 1'b0; x1 = '0; x2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_valid", {31'd0, valid}, 32'd0);
        check_val("rst_y", y, 32'd0);
        check_val("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        check_op("t1", 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0);
        check_op("t2a", 32'hC0400000, 32'h3F000000, 32'hBFC00000, 1'b0);
        check_op("t2b", 32'h80000000, 32'h40490FDB, 32'h80000000, 1'b0);
        check_op("t3a", 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1);
        check_op("t3b", 32'h00800000, 32'h00800000, 32'h00000000, 1'b0);
`ifdef FMUL_ITER_ROUND_EN
        check_op("t4", 32'h3FC00001, 32'h3FC00001, 32'h40100002, 1'b0);
`else
        check_op("t4", 32'h3FC00001, 32'h3FC00001, 32'h40100001, 1'b0);
`endif

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            a = rand_operand();
            b = rand_operand();
            r = ref_mul(a, b);
            check_op($sformatf("rnd%0d", i), a, b, r[31:0], r[32]);
        end

        // Start held high for 40 cycles with operands changing every cycle.
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (i < 40) begin
                ta[i] = rand_operand();
                tb2[i] = rand_operand();
                x1 = ta[i]; x2 = tb2[i]; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (valid) begin
                vcyc.push_back(i);
                vy.push_back(y);
                $display("held-start result at cycle %0d: y=%08h", i, y);
            end
        end
        check_val("held_count", vcyc.size(), 2);
        if (vcyc.size() >= 1) begin
            r = ref_mul(ta[0], tb2[0]);
            check_val("held_cyc0", vcyc[0], LAT);
            check_val("held_y0", vy[0], r[31:0]);
        end
        if (vcyc.size() >= 2) begin
            r = ref_mul(ta[LAT + 1], tb2[LAT + 1]);
            check_val("held_cyc1", vcyc[1], 2 * LAT + 1);
            check_val("held_y1", vy[1], r[31:0]);
        end

        // Reset at cycle 10 of an operation.
        @(negedge clk);
        x1 = 32'h40490FDB; x2 = 32'h3FC00000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_y", y, 32'd0);
        check_val("midrst_valid", {31'd0, valid}, 32'd0);
        check_val("midrst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (valid) stray++;
        end
        check_val("midrst_stray", stray, 0);
        $display("mid-op reset applied, stray valids=%0d", stray);
        check_op("t6", 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
